// File: rtl/mmcm_drp_pkg.sv
// Shared definitions for the MMCM DRP reconfiguration controller:
// register addresses, request limits, FSM states and divider field layout.
package mmcm_drp_pkg;

    localparam logic [6:0] ADDR_FB_REG1  = 7'h14;
    localparam logic [6:0] ADDR_FB_REG2  = 7'h15;
    localparam logic [6:0] ADDR_CO0_REG1 = 7'h08;
    localparam logic [6:0] ADDR_CO0_REG2 = 7'h09;

    localparam logic [6:0] M_MIN = 7'd2;
    localparam logic [6:0] M_MAX = 7'd64;
    localparam logic [6:0] D_MIN = 7'd1;
    localparam logic [6:0] D_MAX = 7'd126;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_ON,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_HOLD,
        S_LOCK_WAIT
    } state_t;

    typedef struct packed {
        logic [5:0] high;
        logic [5:0] low;
        logic       edge_bit;
        logic       no_count;
    } div_fields_t;

    function automatic logic [6:0] reg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return ADDR_FB_REG1;
            2'd1:    return ADDR_FB_REG2;
            2'd2:    return ADDR_CO0_REG1;
            default: return ADDR_CO0_REG2;
        endcase
    endfunction

    function automatic logic cfg_legal(input logic [6:0] m, input logic [6:0] d);
        return (m >= M_MIN) && (m <= M_MAX) && (d >= D_MIN) && (d <= D_MAX);
    endfunction

endpackage

// File: rtl/mmcm_div_calc.sv
// Combinational counter-field calculator: divide value N -> HIGH/LOW/EDGE/NO_COUNT.
// N=1 is the bypass case and uses 1/1 with EDGE cleared.
module mmcm_div_calc
    import mmcm_drp_pkg::*;
(
    input  logic [6:0]  i_n,
    output div_fields_t o_fields
);

    logic       w_one;
    logic [5:0] w_half;

    assign w_one  = (i_n == 7'd1);
    assign w_half = 6'(i_n >> 1);

    always_comb begin
        o_fields.high     = w_one ? 6'd1 : w_half;
        o_fields.low      = w_one ? 6'd1 : 6'(i_n - {1'b0, w_half});
        o_fields.edge_bit = w_one ? 1'b0 : i_n[0];
        o_fields.no_count = w_one;
    end

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// MMCM reconfiguration controller: holds the MMCM in reset, read-modify-writes the
// CLKFBOUT and CLKOUT0 counter registers over DRP, then waits for lock.
module mmcm_drp_ctrl
    import mmcm_drp_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 65535,
    parameter int DRDY_TIMEOUT = 63,
    parameter int RST_HOLD     = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [6:0]  cfg_mult_i,
    input  logic [6:0]  cfg_div0_i,
    output logic [6:0]  drp_daddr_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    input  logic        drp_drdy_i,
    output logic        mmcm_rst_o,
    input  logic        mmcm_locked_i,
    output logic        locked_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int T_MAX0 = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int T_MAX  = (T_MAX0 > RST_HOLD) ? T_MAX0 : RST_HOLD;
    localparam int TW     = $clog2(T_MAX + 1);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_idx;
    logic [TW-1:0] r_timer;
    logic [6:0]  r_m, r_d;
    logic        r_lock_meta, r_lock_sync;
    logic        r_mmcm_rst;
    logic [6:0]  r_daddr;
    logic [15:0] r_di;
    logic        r_done, r_err;

    logic        w_den, w_dwe, w_busy, w_rst_nxt;
    logic        w_accept, w_legal;
    logic        w_drdy_to, w_hold_done, w_lock_to;
    logic        w_drdy_miss, w_lock_miss;
    logic [6:0]  w_n;
    div_fields_t w_f;
    logic [15:0] w_rmw;
    logic        w_unused_do;

    assign w_n = r_idx[1] ? r_d : r_m;

    mmcm_div_calc u_div_calc (
        .i_n      (w_n),
        .o_fields (w_f)
    );

    // Even index is the HIGH/LOW register, odd index the EDGE/NO_COUNT register.
    assign w_rmw = r_idx[0] ? {drp_do_i[15:8], w_f.edge_bit, w_f.no_count, 6'b0}
                            : {drp_do_i[15:12], w_f.high, w_f.low};
    assign w_unused_do = ^drp_do_i[7:0];

    assign w_accept    = (r_state == S_IDLE) && cfg_valid_i;
    assign w_legal     = cfg_legal(cfg_mult_i, cfg_div0_i);
    assign w_drdy_to   = (r_timer == TW'(DRDY_TIMEOUT));
    assign w_hold_done = (r_timer == TW'(RST_HOLD - 1));
    assign w_lock_to   = (r_timer == TW'(LOCK_TIMEOUT));
    assign w_drdy_miss = ((r_state == S_RD_WAIT) || (r_state == S_WR_WAIT)) && !drp_drdy_i && w_drdy_to;
    assign w_lock_miss = (r_state == S_LOCK_WAIT) && !r_lock_sync && w_lock_to;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (cfg_valid_i && w_legal) w_state_nxt = S_RST_ON;
            S_RST_ON:    w_state_nxt = S_RD;
            S_RD:        w_state_nxt = S_RD_WAIT;
            S_RD_WAIT:   if (drp_drdy_i)     w_state_nxt = S_WR;
                         else if (w_drdy_to) w_state_nxt = S_HOLD;
            S_WR:        w_state_nxt = S_WR_WAIT;
            S_WR_WAIT:   if (drp_drdy_i)     w_state_nxt = (r_idx == 2'd3) ? S_HOLD : S_RD;
                         else if (w_drdy_to) w_state_nxt = S_HOLD;
            S_HOLD:      if (w_hold_done)    w_state_nxt = S_LOCK_WAIT;
            S_LOCK_WAIT: if (r_lock_sync || w_lock_to) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_den     = 1'b0;
        w_dwe     = 1'b0;
        w_busy    = (r_state != S_IDLE);
        w_rst_nxt = !((w_state_nxt == S_IDLE) || (w_state_nxt == S_LOCK_WAIT));
        case (r_state)
            S_RD:    w_den = 1'b1;
            S_WR:    begin w_den = 1'b1; w_dwe = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= mmcm_locked_i;
            r_lock_sync <= r_lock_meta;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx      <= 2'd0;
            r_timer    <= '0;
            r_m        <= 7'd0;
            r_d        <= 7'd0;
            r_mmcm_rst <= 1'b1;
            r_daddr    <= 7'd0;
            r_di       <= 16'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_timer    <= (w_state_nxt != r_state) ? '0 : r_timer + 1'b1;
            r_mmcm_rst <= w_rst_nxt;
            r_done     <= (r_state == S_LOCK_WAIT) && r_lock_sync && !r_err;
            if (w_accept) begin
                r_m   <= cfg_mult_i;
                r_d   <= cfg_div0_i;
                r_err <= !w_legal;
            end else if (w_drdy_miss || w_lock_miss) begin
                r_err <= 1'b1;
            end
            if (r_state == S_RST_ON) begin
                r_idx   <= 2'd0;
                r_daddr <= reg_addr(2'd0);
            end
            // Address only moves between accesses, so it is stable from den to drdy.
            if ((r_state == S_WR_WAIT) && drp_drdy_i) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx != 2'd3) r_daddr <= reg_addr(r_idx + 2'd1);
            end
            if ((r_state == S_RD_WAIT) && drp_drdy_i) r_di <= w_rmw;
        end
    end

    assign cfg_ready_o = !w_busy;
    assign busy_o      = w_busy;
    assign drp_den_o   = w_den;
    assign drp_dwe_o   = w_dwe;
    assign drp_daddr_o = r_daddr;
    assign drp_di_o    = r_di;
    assign mmcm_rst_o  = r_mmcm_rst;
    assign locked_o    = r_lock_sync && (r_state == S_IDLE);
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Self-checking bench for mmcm_drp_ctrl: DRP slave and MMCM lock models, a
// per-cycle protocol checker and a transaction-level expected-write model.
module tb_mmcm_drp_ctrl;

    localparam int LOCK_TO = 100;
    localparam int DRDY_TO = 63;
    localparam int HOLD    = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [6:0]  cfg_mult_i = 7'd0;
    logic [6:0]  cfg_div0_i = 7'd0;
    logic [6:0]  drp_daddr_o;
    logic [15:0] drp_di_o;
    logic [15:0] drp_do_i = 16'd0;
    logic        drp_den_o;
    logic        drp_dwe_o;
    logic        drp_drdy_i = 1'b0;
    logic        mmcm_rst_o;
    logic        mmcm_locked_i = 1'b0;
    logic        locked_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    mmcm_drp_ctrl #(
        .LOCK_TIMEOUT (LOCK_TO),
        .DRDY_TIMEOUT (DRDY_TO),
        .RST_HOLD     (HOLD)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_mult_i    (cfg_mult_i),
        .cfg_div0_i    (cfg_div0_i),
        .drp_daddr_o   (drp_daddr_o),
        .drp_di_o      (drp_di_o),
        .drp_do_i      (drp_do_i),
        .drp_den_o     (drp_den_o),
        .drp_dwe_o     (drp_dwe_o),
        .drp_drdy_i    (drp_drdy_i),
        .mmcm_rst_o    (mmcm_rst_o),
        .mmcm_locked_i (mmcm_locked_i),
        .locked_o      (locked_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    // environment state
    logic [15:0] rd_mem [128];
    int          withhold_at = -1;
    bit          lock_en = 1'b1;
    bit          spur_en = 1'b0;
    int          acc_num = 0, pend = 0, lock_cnt = 0, since_rst = 0, cyc = 0;
    bit          outst = 1'b0;
    logic [15:0] pend_data;
    logic [6:0]  hold_addr;
    logic [15:0] hold_di;
    bit          q1 = 1'b0, q2 = 1'b0, prev_rst_o = 1'b1, prev_err = 1'b0;
    int          n_den = 0, n_done = 0, n_busy = 0;
    int          t_wh_den = -1, t_err_rise = -1, t_rst_fall = -1;
    logic [6:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int v, input int lo, input int hi);
        n_chk++;
        if (v < lo || v > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    function automatic logic [6:0] addr_of(input int i);
        case (i)
            0:       return 7'h14;
            1:       return 7'h15;
            2:       return 7'h08;
            default: return 7'h09;
        endcase
    endfunction

    // Expected write word from the field definitions, with plain arithmetic.
    function automatic logic [15:0] model_word(input int i, input int n, input logic [15:0] rd);
        int hi, lo, e, nc;
        if (n == 1) begin hi = 1; lo = 1; e = 0; nc = 1; end
        else begin hi = n / 2; lo = n - hi; e = n % 2; nc = 0; end
        if (i % 2 == 0) return (rd & 16'hF000) | 16'(hi * 64 + lo);
        return (rd & 16'hFF00) | 16'(e * 128 + nc * 64);
    endfunction

    // Per-cycle protocol checker plus DRP slave and lock models.
    always @(negedge clk_i) begin
        cyc++;
        if (rst_i) begin
            since_rst = 0; outst = 1'b0; pend = 0; acc_num = 0;
            drp_drdy_i = 1'b0; mmcm_locked_i = 1'b0; lock_cnt = 0;
            q1 = 1'b0; q2 = 1'b0; prev_rst_o = 1'b1; prev_err = 1'b0;
        end else begin
            since_rst++;
            q2 = q1;
            q1 = mmcm_locked_i;
            check("ready_vs_busy", cfg_ready_o, !busy_o);
            if (drp_dwe_o) check("dwe_needs_den", drp_den_o, 1'b1);
            if (drp_den_o) begin
                check("den_overlap", outst, 1'b0);
                check("rst_high_during_drp", mmcm_rst_o, 1'b1);
            end else if (outst) begin
                check("daddr_stable", drp_daddr_o, hold_addr);
                check("di_stable", drp_di_o, hold_di);
            end
            if (since_rst >= 3) begin
                check("locked_o", locked_o, q2 && !busy_o);
                if (!busy_o) check("mmcm_rst_idle", mmcm_rst_o, 1'b0);
            end
            if (done_o) begin
                n_done++;
                check("done_only_idle", busy_o, 1'b0);
            end
            if (busy_o) n_busy++;
            if (!mmcm_rst_o && prev_rst_o && since_rst >= 2) t_rst_fall = cyc;
            if (err_o && !prev_err) t_err_rise = cyc;
            prev_rst_o = mmcm_rst_o;
            prev_err   = err_o;

            drp_drdy_i = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drp_drdy_i = 1'b1;
                    drp_do_i   = pend_data;
                    outst      = 1'b0;
                end
            end
            if (drp_den_o) begin
                n_den++;
                outst     = 1'b1;
                hold_addr = drp_daddr_o;
                hold_di   = drp_di_o;
                if (drp_dwe_o) begin
                    wr_addr_q.push_back(drp_daddr_o);
                    wr_data_q.push_back(drp_di_o);
                    pend_data = 16'($urandom);
                end else begin
                    pend_data = rd_mem[drp_daddr_o];
                end
                if (acc_num == withhold_at) begin
                    pend = 0;
                    t_wh_den = cyc;
                end else begin
                    pend = $urandom_range(1, 4);
                end
                acc_num++;
            end else if (!outst && !drp_drdy_i && spur_en && $urandom_range(0, 7) == 0) begin
                drp_drdy_i = 1'b1;
                drp_do_i   = 16'($urandom);
            end
            if (!busy_o) begin acc_num = 0; outst = 1'b0; pend = 0; end

            if (mmcm_rst_o) begin
                mmcm_locked_i = 1'b0;
                lock_cnt = 0;
            end else if (lock_en) begin
                if (lock_cnt < 5) lock_cnt++;
                else mmcm_locked_i = 1'b1;
            end else begin
                mmcm_locked_i = 1'b0;
            end
        end
    end

    // One request; wh = access number (reads even, writes odd) whose drdy is withheld.
    task automatic run_cfg(input int m, input int d, input int wh, input bit lk, input bit spur);
        bit legal, exp_err;
        int den0, done0, busy0, k, nw, nd;
        legal = (m >= 2 && m <= 64 && d >= 1 && d <= 126);
        withhold_at = wh; lock_en = lk; spur_en = spur;
        wr_addr_q.delete(); wr_data_q.delete();
        t_wh_den = -1; t_err_rise = -1; t_rst_fall = -1;
        den0 = n_den; done0 = n_done; busy0 = n_busy;
        @(negedge clk_i);
        cfg_mult_i = 7'(m); cfg_div0_i = 7'(d); cfg_valid_i = 1'b1;
        @(posedge clk_i);
        #1 cfg_valid_i = 1'b0;
        check("err_on_accept", err_o, !legal);
        if (!legal) begin
            repeat (20) @(negedge clk_i);
            check("illegal_err_sticky", err_o, 1'b1);
            check("illegal_no_den", n_den - den0, 0);
            check("illegal_no_busy", n_busy - busy0, 0);
            check("illegal_no_done", n_done - done0, 0);
            return;
        end
        k = 0;
        while (busy_o && k < 3000) begin @(negedge clk_i); k++; end
        check("return_to_idle", busy_o, 1'b0);
        repeat (2) @(negedge clk_i);
        exp_err = (wh >= 0) || !lk;
        nw = (wh >= 0) ? (wh + 1) / 2 : 4;
        nd = (wh >= 0) ? wh + 1 : 8;
        check("den_count", n_den - den0, nd);
        check("write_count", wr_data_q.size(), nw);
        for (int i = 0; i < nw && i < wr_data_q.size(); i++) begin
            check("write_addr", wr_addr_q[i], addr_of(i));
            check("write_data", wr_data_q[i],
                  model_word(i, (i < 2) ? m : d, rd_mem[addr_of(i)]));
        end
        check("err_final", err_o, exp_err);
        check("done_count", n_done - done0, exp_err ? 0 : 1);
        if (wh >= 0) begin
            check_rng("drdy_timeout_latency", t_err_rise - t_wh_den, DRDY_TO + 1, DRDY_TO + 3);
            check_rng("rst_hold_after_err", t_rst_fall - t_err_rise, HOLD, HOLD + 2);
        end else if (!lk) begin
            check_rng("lock_timeout_latency", t_err_rise - t_rst_fall, LOCK_TO, LOCK_TO + 3);
        end
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 128; i++) rd_mem[i] = v;
    endtask

    initial begin
        int m, d, wh, sel, k, den0;
        bit lk;
        fill_mem(16'hF000);
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_mmcm_rst", mmcm_rst_o, 1'b1);
        check("rst_den", drp_den_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ready", cfg_ready_o, 1'b1);
        check("rst_err", err_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_locked", locked_o, 1'b0);
        check("rst_daddr", drp_daddr_o, 7'd0);
        check("rst_di", drp_di_o, 16'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1 check("rst_release_fall", mmcm_rst_o, 1'b0);
        repeat (10) @(negedge clk_i);

        // M=10, D=8 against 0xF000 everywhere
        run_cfg(10, 8, -1, 1'b1, 1'b0);
        if (wr_data_q.size() == 4) begin
            check("lit_0x14", wr_data_q[0], 16'hF145);
            check("lit_0x15", wr_data_q[1], 16'hF000);
            check("lit_0x08", wr_data_q[2], 16'hF104);
            check("lit_0x09", wr_data_q[3], 16'hF000);
        end
        fill_mem(16'hABCD);
        run_cfg(10, 7, -1, 1'b1, 1'b0);
        if (wr_data_q.size() == 4) begin
            check("lit_d7_0x08", wr_data_q[2], 16'hA0C4);
            check("lit_d7_0x09", wr_data_q[3], 16'hAB80);
        end
        fill_mem(16'h1234);
        run_cfg(64, 1, -1, 1'b1, 1'b0);
        if (wr_data_q.size() == 4) begin
            check("lit_d1_0x08", wr_data_q[2], 16'h1041);
            check("lit_d1_0x09", wr_data_q[3], 16'h1240);
            check("lit_m64_0x14", wr_data_q[0], 16'h1820);
        end

        // illegal requests and legal boundaries
        run_cfg(1, 8, -1, 1'b1, 1'b0);
        run_cfg(10, 0, -1, 1'b1, 1'b0);
        run_cfg(65, 8, -1, 1'b1, 1'b0);
        run_cfg(10, 127, -1, 1'b1, 1'b0);
        run_cfg(2, 126, -1, 1'b1, 1'b0);

        // missing drdy on the second read, then lock that never comes, then recovery
        run_cfg(10, 8, 2, 1'b1, 1'b0);
        run_cfg(10, 8, -1, 1'b0, 1'b0);
        run_cfg(20, 5, -1, 1'b1, 1'b0);

        // randomized requests with random read data, timeouts and stray drdy
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < 4; i++) rd_mem[addr_of(i)] = 16'($urandom);
            m = $urandom_range(2, 64);
            d = $urandom_range(1, 126);
            if ($urandom_range(0, 5) == 0) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       m = $urandom_range(0, 1);
                    1:       m = $urandom_range(65, 127);
                    2:       d = 0;
                    default: d = 127;
                endcase
            end
            wh = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1;
            lk = (wh < 0 && $urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            run_cfg(m, d, wh, lk, 1'b1);
        end

        // reset while a write is outstanding
        withhold_at = -1; lock_en = 1'b1; spur_en = 1'b0;
        @(negedge clk_i);
        cfg_mult_i = 7'd12; cfg_div0_i = 7'd9; cfg_valid_i = 1'b1;
        @(posedge clk_i);
        #1 cfg_valid_i = 1'b0;
        k = 0;
        do begin @(negedge clk_i); k++; end while (!(drp_den_o && drp_dwe_o) && k < 200);
        check("reach_write", drp_dwe_o, 1'b1);
        #7 rst_i = 1'b1;
        #1;
        check("arst_den", drp_den_o, 1'b0);
        check("arst_dwe", drp_dwe_o, 1'b0);
        check("arst_daddr", drp_daddr_o, 7'd0);
        check("arst_di", drp_di_o, 16'd0);
        check("arst_busy", busy_o, 1'b0);
        check("arst_ready", cfg_ready_o, 1'b1);
        check("arst_mmcm_rst", mmcm_rst_o, 1'b1);
        check("arst_done", done_o, 1'b0);
        check("arst_err", err_o, 1'b0);
        check("arst_locked", locked_o, 1'b0);
        @(negedge clk_i);
        #1 rst_i = 1'b0;
        den0 = n_den;
        repeat (20) @(negedge clk_i);
        check("no_den_after_rst", n_den - den0, 0);
        check("idle_after_rst", busy_o, 1'b0);
        check("mmcm_rst_after_rst", mmcm_rst_o, 1'b0);
        fill_mem(16'h5A5A);
        run_cfg(33, 100, -1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmcm_drp_ctrl.md
MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 65535: cycles to wait for lock after MMCM reset release before flagging error.
REQ-002 Parameter DRDY_TIMEOUT, default 63: cycles to wait for drp_drdy_i after any DRP access before flagging error.
REQ-003 Parameter RST_HOLD, default 8: cycles mmcm_rst_o stays high after the last DRP write.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset:
  clk_i  in  1  DRP clock, also the control clock
  rst_i  in  1  asynchronous active-high reset
  cfg_valid_i  in  1  reconfiguration request
  cfg_ready_o  out  1  request accepted when high with cfg_valid_i
  cfg_mult_i  in  7  feedback multiplier M, legal 2..64
  cfg_div0_i  in  7  CLKOUT0 divider D, legal 1..126
  drp_daddr_o  out  7  DRP address
  drp_di_o  out  16  DRP write data
  drp_do_i  in  16  DRP read data
  drp_den_o  out  1  DRP enable, single-cycle pulse
  drp_dwe_o  out  1  DRP write enable, only with drp_den_o
  drp_drdy_i  in  1  DRP access complete
  mmcm_rst_o  out  1  MMCM reset
  mmcm_locked_i  in  1  raw MMCM lock, asynchronous
  locked_o  out  1  synchronised lock, gated by the FSM
  busy_o  out  1  reconfiguration in progress
  done_o  out  1  one-cycle pulse on successful completion
  err_o  out  1  sticky error, cleared by the next accepted request

Function
REQ-005 mmcm_locked_i SHALL pass through a 2-FF synchroniser; locked_o = synced lock AND state==IDLE.
REQ-006 FSM states: IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, HOLD, LOCK_WAIT.
REQ-007 IDLE: cfg_ready_o=1. On cfg_valid_i, latch M and D and clear err_o. If M or D is illegal, set err_o and stay in IDLE with no DRP or reset activity; otherwise go to RST_ON.
REQ-008 RST_ON: assert mmcm_rst_o, set register index=0, go to RD next cycle. mmcm_rst_o stays high through HOLD.
REQ-009 Register sequence by index 0..3: 0x14 (CLKFBOUT reg1, N=M), 0x15 (CLKFBOUT reg2, N=M), 0x08 (CLKOUT0 reg1, N=D), 0x09 (CLKOUT0 reg2, N=D).
REQ-010 Counter fields: HIGH=floor(N/2), LOW=N-HIGH, EDGE=N[0], NO_COUNT=(N==1). For N=1: HIGH=1, LOW=1, EDGE=0.
REQ-011 Read-modify-write for reg1: di = {rd[15:12], HIGH[5:0], LOW[5:0]}. For reg2: di = {rd[15:8], EDGE, NO_COUNT, 6'b0}.
REQ-012 RD: one-cycle drp_den_o with dwe=0 at the index address. RD_WAIT: capture drp_do_i on drp_drdy_i, then go to WR.
REQ-013 WR: one-cycle drp_den_o and drp_dwe_o with computed di. WR_WAIT: on drp_drdy_i, increment index; go to RD if index<3, else go to HOLD.
REQ-014 Timer: reset on entry to each wait state. If DRDY_TIMEOUT elapses without drdy, set err_o and go to HOLD, abandoning the remaining registers.
REQ-015 drdy arriving outside RD_WAIT/WR_WAIT SHALL be ignored. No second DRP access while one is outstanding.
REQ-016 HOLD: after RST_HOLD cycles, deassert mmcm_rst_o and go to LOCK_WAIT.
REQ-017 LOCK_WAIT: on synced lock, go to IDLE, and pulse done_o if err_o=0. If LOCK_TIMEOUT elapses first, set err_o and go to IDLE.
REQ-018 busy_o = (state != IDLE). cfg_ready_o = (state == IDLE). Requests while busy are not accepted.
REQ-019 drp_daddr_o and drp_di_o SHALL be registered and held stable from den until drdy.

Reset
REQ-020 On rst_i, immediately:
  - state = IDLE, index = 0, timer = 0
  - mmcm_rst_o = 1 while rst_i is high; it falls on the first clock edge after release (IDLE drives 0)
  - den = dwe = 0, daddr = di = 0
  - done_o = 0, err_o = 0, busy_o = 0, locked_o = 0, synchroniser cleared
REQ-021 Reset mid-sequence abandons DRP activity. No access is issued until a new request arrives.

Structure
REQ-022 A shared package mmcm_drp_pkg SHALL hold:
  - DRP address constants 0x14, 0x15, 0x08, 0x09
  - the state enumeration
  - limits M 2..64, D 1..126
REQ-023 Sub-module mmcm_div_calc (combinational N -> HIGH/LOW/EDGE/NO_COUNT) is instantiated once and muxed by index.

Verification
REQ-024 M=10, D=8, DRP model reads 0xF000 everywhere -> writes 0x14=0xF145, 0x15=0xF000, 0x08=0xF104, 0x09=0xF000; then done_o pulses once lock asserts.
REQ-025 D=7 -> 0x08=rd[15:12]|0x0C4, 0x09=rd[15:8]|0x80. D=1 -> 0x08 low bits 0x041, 0x09 low byte 0x40.
REQ-026 M=1 or D=0 -> err_o=1, zero den pulses, mmcm_rst_o stays 0, cfg_ready_o stays 1.
REQ-027 DRP model withholds drdy on the second read -> err_o after DRDY_TIMEOUT+1 cycles; mmcm_rst_o releases after RST_HOLD; no done_o.
REQ-028 Lock never asserts with LOCK_TIMEOUT=100 -> err_o set in about 100 cycles, return to IDLE, the next valid request clears err_o.
REQ-029 rst_i asserted during WR_WAIT -> all outputs at reset values asynchronously; no den after release until a new cfg_valid_i.
